calc_parser: RTL and testbench



---
 rtl/calc_parser.sv | 213 +++++++++++++++++++++
 tb/tb_calc_parser.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_parser.sv
// Byte-serial ASCII expression parser that feeds the calculator ALU.
// Turns "<A><op><B>=" into binary operands, an op code and a hex/dec flag.
module calc_parser #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [1:0]   op,
  output logic         data_type,
  output logic         parser_done,
  output logic         parse_err
);
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_XL    = 8'h78;
  localparam logic [7:0] CH_XU    = 8'h58;

  typedef enum logic [2:0] {IDLE, OPA, OPB, DONE, ERR} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] acc_a_q, acc_a_d;
  logic [W-1:0] acc_b_q, acc_b_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         hex_q, hex_d;
  logic [1:0]   opc_q, opc_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic         dt_q, dt_d;

  logic         consume;
  logic         is_dec;
  logic         is_hex_letter;
  logic         is_op;
  logic         is_x;
  logic         digit_ok;
  logic [3:0]   dig;
  logic [1:0]   op_code;
  logic [W-1:0] acc_sel;
  logic [W+3:0] acc_ext;
  logic [W+3:0] acc_next;
  logic         ovf;
  logic [3:0]   cnt_inc;

  always_comb begin
    is_dec        = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_hex_letter = 1'b0;
    dig           = rx_data[3:0];
    // 'a'-'f' and 'A'-'F' both have low nibble 1..6, so +9 gives 10..15
    if (((rx_data >= 8'h61) && (rx_data <= 8'h66)) ||
        ((rx_data >= 8'h41) && (rx_data <= 8'h46))) begin
      is_hex_letter = 1'b1;
      dig           = rx_data[3:0] + 4'd9;
    end
    is_x    = (rx_data == CH_XL) || (rx_data == CH_XU);
    is_op   = 1'b1;
    op_code = 2'b00;
    case (rx_data)
      CH_PLUS:  op_code = 2'b00;
      CH_MINUS: op_code = 2'b01;
      CH_MUL:   op_code = 2'b10;
      CH_DIV:   op_code = 2'b11;
      default:  is_op   = 1'b0;
    endcase
    digit_ok = is_dec | (hex_q & is_hex_letter);
  end

  // Four spare bits hold the largest acc*16+15, so overflow is just the top nibble.
  assign acc_sel  = (state_q == OPB) ? acc_b_q : acc_a_q;
  assign acc_ext  = {4'b0000, acc_sel};
  assign acc_next = (hex_q ? (acc_ext << 4) : ((acc_ext << 3) + (acc_ext << 1)))
                    + {{W{1'b0}}, dig};
  assign ovf      = |acc_next[W+3:W];
  assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign consume  = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_a_q <= '0;
      acc_b_q <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      opc_q   <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      dt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dt_q    <= dt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dt_d    = dt_q;
    case (state_q)
      DONE, ERR: begin
        state_d = IDLE;
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
      end
      default: begin
        if (consume) begin
          if (rx_data == CH_ESC) begin
            state_d = IDLE;
            acc_a_d = '0;
            acc_b_d = '0;
            cnt_d   = '0;
          end else if (rx_data != CH_SPACE) begin
            case (state_q)
              IDLE: begin
                if (is_x) begin
                  hex_d   = 1'b1;
                  acc_a_d = '0;
                  cnt_d   = '0;
                  state_d = OPA;
                end else if (is_dec) begin
                  hex_d   = 1'b0;
                  acc_a_d = {{(W-4){1'b0}}, dig};
                  cnt_d   = 4'd1;
                  state_d = OPA;
                end else begin
                  state_d = ERR;
                end
              end
              OPA: begin
                if (digit_ok) begin
                  if (ovf) begin
                    state_d = ERR;
                  end else begin
                    acc_a_d = acc_next[W-1:0];
                    cnt_d   = cnt_inc;
                  end
                end else if (is_op && (cnt_q != 4'd0)) begin
                  opc_d   = op_code;
                  acc_b_d = '0;
                  cnt_d   = '0;
                  state_d = OPB;
                end else begin
                  state_d = ERR;
                end
              end
              OPB: begin
                if (digit_ok) begin
                  if (ovf) begin
                    state_d = ERR;
                  end else begin
                    acc_b_d = acc_next[W-1:0];
                    cnt_d   = cnt_inc;
                  end
                end else if ((rx_data == CH_EQ) && (cnt_q != 4'd0) &&
                             !((opc_q == 2'b11) && (acc_b_q == '0))) begin
                  // Divide-by-zero is rejected here since the ALU has no guard.
                  a_d     = acc_a_q;
                  b_d     = acc_b_q;
                  op_d    = opc_q;
                  dt_d    = hex_q;
                  state_d = DONE;
                end else begin
                  state_d = ERR;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    rx_ready    = (state_q == IDLE) || (state_q == OPA) || (state_q == OPB);
    parser_done = (state_q == DONE);
    parse_err   = (state_q == ERR);
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign data_type = dt_q;

  assert property (@(posedge clk) disable iff (!rst_n) !(parser_done && parse_err));

endmodule

// File: tb/tb_calc_parser.sv
// Self-checking bench for calc_parser: expression table, hand-written corner
// sequences and random character streams against a character-level model.
module tb_calc_parser;
  localparam int W = 16;
  localparam longint LIMIT = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         data_type, parser_done, parse_err;

  calc_parser #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .a(a), .b(b), .op(op), .data_type(data_type),
    .parser_done(parser_done), .parse_err(parse_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_err = 0;

  // Reference model: expression phase (0 idle, 1 first number, 2 second number)
  int           m_phase;
  bit           m_hex;
  longint       m_acc[2];
  int           m_cnt;
  int           m_opc;
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_op;
  logic         m_dt;
  bit           m_done, m_err;

  typedef struct {
    string s;
    int    ea, eb, eop, edt, nd, ne;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input logic [7:0] c, input bit hex);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (hex && c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
    if (hex && c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    return -1;
  endfunction

  function automatic int opcode_of(input logic [7:0] c);
    case (c)
      "+": return 0;
      "-": return 1;
      "*": return 2;
      "/": return 3;
      default: return -1;
    endcase
  endfunction

  task automatic m_clear();
    m_phase = 0;
    m_acc[0] = 0;
    m_acc[1] = 0;
    m_cnt = 0;
  endtask

  task automatic m_fail();
    m_err = 1;
    m_clear();
  endtask

  task automatic m_reset();
    m_clear();
    m_hex = 0; m_opc = 0;
    m_a = '0; m_b = '0; m_op = 2'b00; m_dt = 1'b0;
    m_done = 0; m_err = 0;
  endtask

  task automatic m_consume(input logic [7:0] c);
    int d;
    int idx;
    longint nv;
    if (c == 8'h1B) begin m_clear(); return; end
    if (c == " ") return;
    if (m_phase == 0) begin
      if (c == "x" || c == "X") begin
        m_hex = 1; m_acc[0] = 0; m_cnt = 0; m_phase = 1;
      end else if (digit_of(c, 0) >= 0) begin
        m_hex = 0; m_acc[0] = digit_of(c, 0); m_cnt = 1; m_phase = 1;
      end else m_fail();
      return;
    end
    idx = m_phase - 1;
    d = digit_of(c, m_hex);
    if (d >= 0) begin
      nv = m_acc[idx] * (m_hex ? 16 : 10) + d;
      if (nv > LIMIT) m_fail();
      else begin m_acc[idx] = nv; m_cnt++; end
    end else if (m_phase == 1 && opcode_of(c) >= 0) begin
      if (m_cnt == 0) m_fail();
      else begin m_opc = opcode_of(c); m_cnt = 0; m_acc[1] = 0; m_phase = 2; end
    end else if (m_phase == 2 && c == "=") begin
      if (m_cnt == 0 || (m_opc == 3 && m_acc[1] == 0)) m_fail();
      else begin
        m_a = m_acc[0][W-1:0]; m_b = m_acc[1][W-1:0];
        m_op = m_opc[1:0]; m_dt = m_hex; m_done = 1;
        m_clear();
      end
    end else m_fail();
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input logic v, input logic [7:0] c, output bit cons);
    rx_valid = v;
    rx_data = c;
    cons = v && (rx_ready === 1'b1);
    @(posedge clk);
    m_done = 0;
    m_err = 0;
    if (cons) m_consume(c);
    @(negedge clk);
    if (parser_done === 1'b1) n_done++;
    if (parse_err === 1'b1) n_err++;
    check("parser_done", {31'd0, parser_done}, {31'd0, m_done});
    check("parse_err", {31'd0, parse_err}, {31'd0, m_err});
    check("rx_ready", {31'd0, rx_ready}, {31'd0, !(m_done || m_err)});
    check("a", {16'd0, a}, {16'd0, m_a});
    check("b", {16'd0, b}, {16'd0, m_b});
    check("op", {30'd0, op}, {30'd0, m_op});
    check("data_type", {31'd0, data_type}, {31'd0, m_dt});
  endtask

  task automatic send_char(input logic [7:0] c);
    bit cons;
    cons = 0;
    for (int t = 0; t < 4 && !cons; t++) step(1'b1, c, cons);
    check("accept", {31'd0, cons}, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit cons;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, cons);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic add_vec(input string s, input int ea, input int eb, input int eop,
                         input int edt, input int nd, input int ne);
    vec_t v;
    v.s = s; v.ea = ea; v.eb = eb; v.eop = eop; v.edt = edt; v.nd = nd; v.ne = ne;
    tbl.push_back(v);
  endtask

  task automatic check_result(input string tag, input int ea, input int eb, input int eop,
                              input int edt, input int nd, input int ne);
    check({tag, ".a"}, {16'd0, a}, ea);
    check({tag, ".b"}, {16'd0, b}, eb);
    check({tag, ".op"}, {30'd0, op}, eop);
    check({tag, ".data_type"}, {31'd0, data_type}, edt);
    check({tag, ".done_pulses"}, n_done, nd);
    check({tag, ".err_pulses"}, n_err, ne);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    string alpha;
    bit cons;
    logic [7:0] c;

    m_reset();
    #1;
    check("reset.a", {16'd0, a}, 0);
    check("reset.b", {16'd0, b}, 0);
    check("reset.op", {30'd0, op}, 0);
    check("reset.data_type", {31'd0, data_type}, 0);
    check("reset.parser_done", {31'd0, parser_done}, 0);
    check("reset.parse_err", {31'd0, parse_err}, 0);
    check("reset.rx_ready", {31'd0, rx_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    add_vec("123+45=",     123,   45,  0, 0, 1, 0);
    add_vec("xFFFF*a=",    65535, 10,  2, 1, 1, 0);
    add_vec("65536-1=",    65535, 10,  2, 1, 0, 3);
    add_vec("7/0=",        65535, 10,  2, 1, 0, 1);
    add_vec("8/2=",        8,     2,   3, 0, 1, 0);
    add_vec("+5=",         8,     2,   3, 0, 0, 2);
    add_vec("12=",         8,     2,   3, 0, 0, 1);
    add_vec("3a+1=",       8,     2,   3, 0, 0, 3);
    add_vec("65535-0=",    65535, 0,   1, 0, 1, 0);
    add_vec("x+1=",        65535, 0,   1, 0, 0, 2);
    add_vec("x10000+1=",   65535, 0,   1, 0, 0, 3);
    add_vec(" xAb /  3=",  171,   3,   3, 1, 1, 0);
    add_vec("x8/0=",       171,   3,   3, 1, 0, 1);
    add_vec("9x=",         171,   3,   3, 1, 0, 2);

    foreach (tbl[i]) begin
      n_done = 0;
      n_err = 0;
      send_str(tbl[i].s);
      idle(1);
      $display("vec %0d \"%s\": a=%0d b=%0d op=%0d dt=%0d done=%0d err=%0d",
               i, tbl[i].s, a, b, op, data_type, n_done, n_err);
      check_result($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eop,
                   tbl[i].edt, tbl[i].nd, tbl[i].ne);
    end

    // Gaps, spaces and ESC in the middle of an expression
    n_done = 0;
    n_err = 0;
    send_char("1"); idle(2); send_char("2"); send_char(" "); idle(1);
    send_char("+"); idle(3); send_char(8'h1B); send_char(8'h1B);
    send_char("9"); idle(1); send_char("-"); send_char("4"); idle(2); send_char("=");
    idle(1);
    $display("seq esc: a=%0d b=%0d op=%0d done=%0d err=%0d", a, b, op, n_done, n_err);
    check_result("esc", 9, 4, 1, 0, 1, 0);

    // Asynchronous reset in the middle of the first operand
    send_str("45");
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("midrst.a", {16'd0, a}, 0);
    check("midrst.b", {16'd0, b}, 0);
    check("midrst.op", {30'd0, op}, 0);
    check("midrst.parser_done", {31'd0, parser_done}, 0);
    check("midrst.parse_err", {31'd0, parse_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_err = 0;
    send_str("1+1=");
    idle(1);
    $display("seq reset: a=%0d b=%0d op=%0d done=%0d err=%0d", a, b, op, n_done, n_err);
    check_result("after_rst", 1, 1, 0, 0, 1, 0);

    // Random character streams with random valid gaps
    alpha = "0123456789abcdefxX+-*/= 0123456789=+-*/00";
    n_done = 0;
    n_err = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) step(1'b0, 8'($urandom), cons);
      if ($urandom_range(29) == 0) c = 8'h1B;
      else c = alpha[$urandom_range(alpha.len() - 1)];
      send_char(c);
    end
    idle(2);
    $display("random: done=%0d err=%0d", n_done, n_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
